i2c_reg_target: RTL and testbench

I2C responder holding a small byte-addressable register bank, shared with the master over the same `i2c_sda`/`i2c_scl` bus. It decodes START, address, pointer and data phases driven by the master. It ACKs its own 7-bit address, accepts pointer/data writes and returns register contents on reads. The bank's contents are exposed in parallel so board logic can consume values configured over I2C.

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_line_sync.sv | 57 +++++
 rtl/i2c_reg_target.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, bus bit meanings and
// byte framing constants used by the target and the line conditioner.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_WAIT_STOP
   } i2c_state_t;

   // Level on SDA during the ninth (acknowledge) bit
   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;

   // R/W bit carried in bit 0 of the address byte
   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   // Bit counter value on the rising edge that completes a byte
   localparam logic [3:0] I2C_LAST_BIT  = 4'd7;
   localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

   // 7-bit bus address carried in an address byte
   function automatic logic [6:0] i2c_addr_of(input logic [7:0] addr_byte);
      return addr_byte[7:1];
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line conditioner: brings SCL/SDA into the clk domain through two flops
// each and derives SCL edges plus START/STOP conditions from the synchronized
// levels. Shared between the I2C target and master.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync_q, scl_sync_d;
   logic [1:0] sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d;
   logic       sda_prev_q, sda_prev_d;
   logic       scl_s, sda_s;

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];

   // Next values of the synchronizer chains and the edge-detect history
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   // Flops come out of reset at the idle-bus level so no edge is seen on release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   // SDA moving while SCL is held high marks START (falling) or STOP (rising)
   always_comb begin
      sda       = sda_s;
      scl_rise  = scl_s & ~scl_prev_q;
      scl_fall  = ~scl_s & scl_prev_q;
      start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
      stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
   end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C responder with a small byte-addressable register bank. A write sets the
// pointer and then fills consecutive registers; a read streams consecutive
// registers from the current pointer. The bank is exposed in parallel.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | bus free or not addressed, SDA released
//   ST_ADDR      | shifting in address byte (bit 0 is R/W)
//   ST_ADDR_ACK  | address matched, driving ACK for one SCL pulse
//   ST_PTR       | shifting in pointer byte
//   ST_PTR_ACK   | driving ACK for the pointer byte
//   ST_WDATA     | shifting in a data byte for register[pointer]
//   ST_WDATA_ACK | driving ACK for a data byte
//   ST_RDATA     | driving register[pointer] onto SDA, MSB first
//   ST_RACK      | SDA released, sampling the master's ACK/NACK
//   ST_WAIT_STOP | not addressed or master NACKed; ignore until STOP/START
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NREGS      = 4
) (
   input  logic               clk,
   input  logic               reset,
   inout  wire                i2c_sda,
   inout  wire                i2c_scl,
   output logic [8*NREGS-1:0] regs_out,
   output logic               busy,
   output logic               wr_pulse
);

   localparam int PTR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   i2c_state_t                  state_q, state_d;
   logic [3:0]                  bit_cnt_q, bit_cnt_d;
   logic [7:0]                  shift_q, shift_d;
   logic [PTR_W-1:0]            ptr_q, ptr_d;
   logic [NREGS-1:0][7:0]       regs_q, regs_d;
   logic                        sda_low_q, sda_low_d;
   logic                        busy_q, busy_d;
   logic                        wr_pulse_q, wr_pulse_d;

   logic                        sda_s;
   logic                        scl_rise, scl_fall;
   logic                        start_det, stop_det;
   logic [7:0]                  rx_byte;
   logic [7:0]                  rd_byte;
   logic [PTR_W-1:0]            ptr_inc;

   i2c_line_sync u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (i2c_scl),
      .sda_in    (i2c_sda),
      .sda       (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // Open-drain: only ever pull SDA low; SCL is observed, never driven
   assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
   assign i2c_scl  = 1'bz;
   assign regs_out = regs_q;
   assign busy     = busy_q;
   assign wr_pulse = wr_pulse_q;

   assign rx_byte = {shift_q[6:0], sda_s};
   assign rd_byte = regs_q[ptr_q];
   assign ptr_inc = ptr_q + PTR_W'(1);

   // Next-state logic; bus conditions pre-empt any bit handling in progress
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      regs_d     = regs_q;
      sda_low_d  = sda_low_q;
      busy_d     = busy_q;
      wr_pulse_d = 1'b0;

      if (stop_det) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  if (bit_cnt_q != I2C_LAST_BIT) begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end else begin
                     bit_cnt_d = '0;
                     case (state_q)
                        ST_ADDR: begin
                           if (i2c_addr_of(rx_byte) == SLAVE_ADDR) begin
                              state_d = ST_ADDR_ACK;
                              busy_d  = 1'b1;
                           end else begin
                              state_d = ST_WAIT_STOP;
                           end
                        end
                        ST_PTR: begin
                           ptr_d   = rx_byte[PTR_W-1:0];
                           state_d = ST_PTR_ACK;
                        end
                        default: begin
                           regs_d[ptr_q] = rx_byte;
                           wr_pulse_d    = 1'b1;
                           ptr_d         = ptr_inc;
                           state_d       = ST_WDATA_ACK;
                        end
                     endcase
                  end
               end
            end

            // bit_cnt 0: waiting for the fall that opens the ACK slot;
            // bit_cnt 1: ACK is on the bus, the next fall closes the slot
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (bit_cnt_q == '0) begin
                     sda_low_d = ~I2C_ACK;
                     bit_cnt_d = 4'd1;
                  end else begin
                     bit_cnt_d = '0;
                     sda_low_d = 1'b0;
                     if (state_q == ST_ADDR_ACK && shift_q[0] == I2C_READ) begin
                        shift_d   = rd_byte;
                        sda_low_d = ~rd_byte[7];
                        state_d   = ST_RDATA;
                     end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_PTR;
                     end else begin
                        state_d = ST_WDATA;
                     end
                  end
               end
            end

            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == I2C_BYTE_BITS) begin
                  bit_cnt_d = '0;
                  sda_low_d = 1'b0;
                  ptr_d     = ptr_inc;
                  state_d   = ST_RACK;
               end else if (scl_fall && bit_cnt_q != '0) begin
                  shift_d   = {shift_q[6:0], shift_q[7]};
                  sda_low_d = ~shift_q[6];
               end
            end

            // bit_cnt records what the master sent: 1 = ACK, 2 = NACK
            ST_RACK: begin
               if (scl_rise) begin
                  bit_cnt_d = (sda_s == I2C_ACK) ? 4'd1 : 4'd2;
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = '0;
                  shift_d   = rd_byte;
                  sda_low_d = ~rd_byte[7];
                  state_d   = ST_RDATA;
               end else if (scl_fall && bit_cnt_q == 4'd2) begin
                  bit_cnt_d = '0;
                  state_d   = ST_WAIT_STOP;
               end
            end

            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State, datapath and bank registers; reset releases SDA immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         regs_q     <= '0;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         regs_q     <= regs_d;
         sda_low_q  <= sda_low_d;
         busy_q     <= busy_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged bus master applies a table of
// transactions, expected ACKs and read bytes go through a scoreboard queue,
// and two hand-written sequences cover STOP mid-byte and reset mid-ACK.
module tb_i2c_reg_target;
   import i2c_pkg::*;

   localparam int Q = 80;   // quarter SCL period = 8 clk, SCL = clk/32

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        scl_lo = 1'b0;
   logic        sda_lo = 1'b0;
   wire         scl_bus;
   wire         sda_bus;
   logic [31:0] regs_out;
   logic        busy;
   logic        wr_pulse;

   assign scl_bus = scl_lo ? 1'b0 : 1'bz;
   assign sda_bus = sda_lo ? 1'b0 : 1'bz;
   pullup (scl_bus);
   pullup (sda_bus);

   always #5 clk = ~clk;

   i2c_reg_target #(.SLAVE_ADDR(7'h50), .NREGS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .i2c_sda  (sda_bus),
      .i2c_scl  (scl_bus),
      .regs_out (regs_out),
      .busy     (busy),
      .wr_pulse (wr_pulse)
   );

   typedef struct {
      bit          is_read;
      logic [6:0]  addr;
      bit          set_ptr;
      logic [7:0]  ptr;
      int          n;
      logic [31:0] data;      // byte k at [8k+7:8k]
      bit          exp_ack;   // target expected to answer
      logic [31:0] exp_regs;  // {reg3, reg2, reg1, reg0} after STOP
      int          exp_pulses;
   } vec_t;

   int          n_checks  = 0;
   int          n_pass    = 0;
   int          pulse_cnt = 0;
   int          busy_cnt  = 0;
   logic [7:0]  exp_q[$];
   vec_t        vecs[9];

   always @(negedge clk) begin
      if (wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
      if (busy === 1'b1)     busy_cnt  <= busy_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected summary");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(bit rd, logic [6:0] a, bit sp, logic [7:0] p, int n,
                               logic [31:0] d, bit ack, logic [31:0] r, int pulses);
      vec_t v;
      v.is_read = rd; v.addr = a; v.set_ptr = sp; v.ptr = p; v.n = n;
      v.data = d; v.exp_ack = ack; v.exp_regs = r; v.exp_pulses = pulses;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic sb_check(input string name, input logic [7:0] act);
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: got 0x%0h, expected an entry in empty scoreboard", name, act);
      end else begin
         check(name, 32'(act), 32'(exp_q.pop_front()));
      end
   endtask

   // All bit tasks enter and leave with SCL low, one quarter after the fall
   task automatic bit_out(input logic b);
      sda_lo = ~b; #Q; scl_lo = 1'b0; #(2*Q); scl_lo = 1'b1; #Q;
   endtask

   task automatic bit_in(output logic b);
      sda_lo = 1'b0; #Q; scl_lo = 1'b0; #Q; b = sda_bus; #Q; scl_lo = 1'b1; #Q;
   endtask

   task automatic bus_start();
      sda_lo = 1'b1; #Q; scl_lo = 1'b1; #Q;
   endtask

   task automatic bus_restart();
      sda_lo = 1'b0; #Q; scl_lo = 1'b0; #Q; sda_lo = 1'b1; #Q; scl_lo = 1'b1; #Q;
   endtask

   task automatic bus_stop();
      sda_lo = 1'b1; #Q; scl_lo = 1'b0; #Q; sda_lo = 1'b0; #(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(b[i]);
      bit_in(ack);
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic mack);
      logic bi;
      for (int i = 7; i >= 0; i--) begin
         bit_in(bi);
         b[i] = bi;
      end
      bit_out(mack);
   endtask

   task automatic do_vec(input vec_t v, input int idx);
      logic       ack;
      logic [7:0] b;
      logic [7:0] ack_exp;
      int         pb, bb;
      pb = pulse_cnt;
      bb = busy_cnt;
      ack_exp = {7'b0, v.exp_ack ? I2C_ACK : I2C_NACK};
      bus_start();
      if (!v.is_read || v.set_ptr) begin
         exp_q.push_back(ack_exp);
         send_byte({v.addr, I2C_WRITE}, ack);
         sb_check($sformatf("v%0d_addr_w_ack", idx), {7'b0, ack});
         if (v.set_ptr) begin
            exp_q.push_back(ack_exp);
            send_byte(v.ptr, ack);
            sb_check($sformatf("v%0d_ptr_ack", idx), {7'b0, ack});
         end
      end
      if (!v.is_read) begin
         for (int k = 0; k < v.n; k++) begin
            exp_q.push_back(ack_exp);
            send_byte(v.data[8*k +: 8], ack);
            sb_check($sformatf("v%0d_data%0d_ack", idx, k), {7'b0, ack});
         end
         check($sformatf("v%0d_busy_mid", idx), 32'(busy), 32'(v.exp_ack));
      end else begin
         if (v.set_ptr) bus_restart();
         exp_q.push_back(ack_exp);
         send_byte({v.addr, I2C_READ}, ack);
         sb_check($sformatf("v%0d_addr_r_ack", idx), {7'b0, ack});
         check($sformatf("v%0d_busy_mid", idx), 32'(busy), 32'(v.exp_ack));
         for (int k = 0; k < v.n; k++) begin
            exp_q.push_back(v.data[8*k +: 8]);
            recv_byte(b, (k == v.n - 1) ? I2C_NACK : I2C_ACK);
            sb_check($sformatf("v%0d_rd%0d", idx, k), b);
         end
         check($sformatf("v%0d_sda_rel_nack", idx), 32'(sda_bus), 32'd1);
      end
      bus_stop();
      check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_regs", idx), regs_out, v.exp_regs);
      check($sformatf("v%0d_pulses", idx), 32'(pulse_cnt - pb), 32'(v.exp_pulses));
      check($sformatf("v%0d_busy_seen", idx), 32'(busy_cnt != bb), 32'(v.exp_ack));
   endtask

   initial begin
      logic       ack;
      logic [7:0] a_byte;
      int         pb;

      vecs[0] = mk(0, 7'h50, 1, 8'h01, 2, 32'h0000_3CA5, 1, 32'h003C_A500, 2);
      vecs[1] = mk(0, 7'h50, 1, 8'h03, 2, 32'h0000_2211, 1, 32'h113C_A522, 2);
      vecs[2] = mk(0, 7'h50, 1, 8'h00, 3, 32'h007C_6B5A, 1, 32'h117C_6B5A, 3);
      vecs[3] = mk(1, 7'h50, 1, 8'h00, 3, 32'h007C_6B5A, 1, 32'h117C_6B5A, 0);
      vecs[4] = mk(0, 7'h51, 1, 8'h02, 1, 32'h0000_00EE, 0, 32'h117C_6B5A, 0);
      vecs[5] = mk(1, 7'h50, 0, 8'h00, 2, 32'h0000_5A11, 1, 32'h117C_6B5A, 0);
      vecs[6] = mk(0, 7'h50, 1, 8'h05, 1, 32'h0000_0077, 1, 32'h117C_775A, 1);
      vecs[7] = mk(0, 7'h50, 1, 8'h01, 1, 32'h0000_0099, 1, 32'h0000_9900, 1);
      vecs[8] = mk(1, 7'h50, 1, 8'h01, 1, 32'h0000_0099, 1, 32'h0000_9900, 0);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_regs", regs_out, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("rst_sda", 32'(sda_bus), 32'd1);

      for (int i = 0; i < 7; i++) do_vec(vecs[i], i);

      // STOP after four data bits: partial byte must be dropped
      pb = pulse_cnt;
      bus_start();
      send_byte({7'h50, I2C_WRITE}, ack);
      check("abort_addr_ack", 32'(ack), 32'(I2C_ACK));
      send_byte(8'h02, ack);
      check("abort_ptr_ack", 32'(ack), 32'(I2C_ACK));
      bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
      bus_stop();
      check("abort_regs", regs_out, 32'h117C_775A);
      check("abort_pulses", 32'(pulse_cnt - pb), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_sda", 32'(sda_bus), 32'd1);
      check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));

      // Reset while the target holds the address ACK low
      a_byte = {7'h50, I2C_WRITE};
      bus_start();
      for (int i = 7; i >= 0; i--) bit_out(a_byte[i]);
      sda_lo = 1'b0;
      #1;
      check("mid_ack_sda_low", 32'(sda_bus), 32'd0);
      reset = 1'b1;
      #1;
      check("rst_ack_sda_rel", 32'(sda_bus), 32'd1);
      check("rst_ack_regs", regs_out, 32'h0);
      check("rst_ack_busy", 32'(busy), 32'd0);
      check("rst_ack_wr_pulse", 32'(wr_pulse), 32'd0);
      check("rst_ack_ptr", 32'(dut.ptr_q), 32'd0);
      scl_lo = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      do_vec(vecs[7], 7);
      do_vec(vecs[8], 8);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
